// File: rtl/accum_rr_scheduler.sv
// Round-robin shared accumulator: four requesters feed one adder under a req/ack handshake.
// Optional build macro ACCUM_SAT_EN makes the sum saturate on overflow instead of wrapping.
module accum_rr_scheduler #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SUM_W  = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    count,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] data_in,
  output logic [3:0]          ack,
  output logic [SUM_W-1:0]    sum,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [SUM_W-1:0]   r_sum;
  logic [CNT_W-1:0]   r_rem;
  logic [1:0]         r_ptr;
  logic               r_ovf;

  logic [3:0]         w_ack;
  logic [1:0]         w_idx;
  logic               w_found;
  logic               w_accept;
  logic [DATA_W-1:0]  w_data;
  logic [SUM_W:0]     w_opnd;
  logic [SUM_W:0]     w_add;
  logic               w_carry;
  logic [SUM_W-1:0]   w_sum_next;

  // First requester at or after the pointer, searching upward mod 4.
  always_comb begin
    logic [1:0] cand;
    w_ack   = '0;
    w_idx   = r_ptr;
    w_found = 1'b0;
    cand    = r_ptr;
    for (int k = 0; k < 4; k++) begin
      cand = r_ptr + 2'(k);
      if (!w_found && req[cand]) begin
        w_found = 1'b1;
        w_idx   = cand;
      end
    end
    if (r_state == StAccum && w_found) begin
      w_ack[w_idx] = 1'b1;
    end
  end

  assign w_accept = |w_ack;
  assign w_data   = data_in[w_idx*DATA_W +: DATA_W];

  always_comb begin
    w_opnd               = '0;
    w_opnd[DATA_W-1:0]   = w_data;
    w_add                = {1'b0, r_sum} + w_opnd;
    w_carry              = w_add[SUM_W];
`ifdef ACCUM_SAT_EN
    // Once at all-ones, any further nonzero add carries again, so the sum stays pinned.
    w_sum_next           = w_carry ? {SUM_W{1'b1}} : w_add[SUM_W-1:0];
`else
    w_sum_next           = w_add[SUM_W-1:0];
`endif
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = (count != '0) ? StAccum : StDone;
        end
      end
      StAccum: begin
        if (w_accept && r_rem == CNT_W'(1)) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sum   <= '0;
      r_rem   <= '0;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && start) begin
        r_sum <= '0;
        r_ovf <= 1'b0;
        r_rem <= count;
      end else if (w_accept) begin
        r_sum <= w_sum_next;
        r_rem <= r_rem - CNT_W'(1);
        r_ptr <= w_idx + 2'd1;
        if (w_carry) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign ack  = w_ack;
  assign sum  = r_sum;
  assign busy = (r_state == StAccum);
  assign done = (r_state == StDone);
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_accum_rr_scheduler.sv
// Directed bench for accum_rr_scheduler: expected grants and running sums are queued per job
// and popped as the DUT acknowledges requesters.
module tb_accum_rr_scheduler;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SUM_W  = 16;
  localparam int unsigned CNT_W  = 8;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [CNT_W-1:0]    count;
  logic [3:0]          req;
  logic [4*DATA_W-1:0] data_in;
  logic [3:0]          ack;
  logic [SUM_W-1:0]    sum;
  logic                busy;
  logic                done;
  logic                ovf;

  typedef struct {
    logic [3:0]       ack;
    logic [SUM_W-1:0] sum;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  accum_rr_scheduler #(
    .DATA_W(DATA_W),
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .count  (count),
    .req    (req),
    .data_in(data_in),
    .ack    (ack),
    .sum    (sum),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [SUM_W-1:0] s);
    exp_t e;
    e.ack = a;
    e.sum = s;
    sb.push_back(e);
  endtask

  task automatic set_lanes(input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3);
    data_in = {d3, d2, d1, d0};
  endtask

  // Runs one job from an IDLE negedge. gap_after: accepts before dropping req for 3 cycles
  // (-1 = none). start_at: loop iteration at which a stray start is pulsed (-1 = none).
  task automatic job(input string name, input int n, input logic [3:0] rq,
                     input int gap_after, input int start_at);
    logic [SUM_W-1:0] exp_final;
    int               accepts;
    int               gap_left;
    bit               gap_done;
    bit               got_done;
    int               it;
    exp_t             e;
    exp_final = '0;
    accepts   = 0;
    gap_left  = 0;
    gap_done  = 1'b0;
    got_done  = 1'b0;
    it        = 0;
    start = 1'b1;
    count = CNT_W'(n);
    req   = rq;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".busy_after_start"}, 32'(busy), 32'(n != 0));
    chk({name, ".ovf_cleared"}, 32'(ovf), 32'd0);
    while (!got_done && it < 60) begin
      chk({name, ".sum_track"}, 32'(sum), 32'(exp_final));
      if (done) begin
        got_done = 1'b1;
        chk({name, ".busy_in_done"}, 32'(busy), 32'd0);
        chk({name, ".ack_in_done"}, 32'(ack), 32'd0);
        chk({name, ".sb_empty"}, 32'(sb.size()), 32'd0);
      end else begin
        if (accepts == gap_after && !gap_done) begin
          gap_done = 1'b1;
          gap_left = 3;
        end
        if (gap_left > 0) begin
          req = 4'b0000;
          gap_left--;
        end else begin
          req = rq;
        end
        start = (it == start_at);
        count = CNT_W'(1);
        #1;
        if (req == 4'b0000) begin
          chk({name, ".ack_gap"}, 32'(ack), 32'd0);
        end else if (ack != 4'b0000) begin
          if (sb.size() == 0) begin
            chk({name, ".unexpected_ack"}, 32'(ack), 32'd0);
          end else begin
            e = sb.pop_front();
            chk({name, ".ack"}, 32'(ack), 32'(e.ack));
            exp_final = e.sum;
            accepts++;
          end
        end
        @(negedge clk);
        start = 1'b0;
      end
      it++;
    end
    if (!got_done) begin
      chk({name, ".timeout"}, 32'd0, 32'd1);
    end
    chk({name, ".final_sum"}, 32'(sum), 32'(exp_final));
    sb.delete();
    req = 4'b0000;
    @(negedge clk);
    chk({name, ".done_one_cycle"}, 32'(done), 32'd0);
    chk({name, ".idle_busy"}, 32'(busy), 32'd0);
    chk({name, ".sum_holds"}, 32'(sum), 32'(exp_final));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    count    = '0;
    req      = 4'b1111;
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    repeat (2) @(negedge clk);
    chk("reset.ack", 32'(ack), 32'd0);
    chk("reset.sum", 32'(sum), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    req   = 4'b0000;
    @(negedge clk);

    // Reset mid-job: two accepts move the pointer, then abort.
    start = 1'b1;
    count = CNT_W'(8);
    req   = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst.sum_before", 32'(sum), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst.sum", 32'(sum), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.ack", 32'(ack), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    @(negedge clk);
    chk("midrst.no_done", 32'(done), 32'd0);
    req   = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic job: pointer back at 0 after reset.
    push(4'b0001, 16'd1);
    push(4'b0010, 16'd3);
    push(4'b0100, 16'd6);
    push(4'b1000, 16'd10);
    job("basic", 4, 4'b1111, -1, -1);
    chk("basic.ovf", 32'(ovf), 32'd0);

    // Round-robin resume with sparse requesters.
    set_lanes(16'd5, 16'd100, 16'd7, 16'd200);
    push(4'b0001, 16'd5);
    push(4'b0100, 16'd12);
    push(4'b0001, 16'd17);
    job("rr", 3, 4'b0101, -1, -1);

    job("zero", 0, 4'b1111, -1, -1);

    // Overflow on lane 0: 0xFFFF + 0xFFFF.
    set_lanes(16'hFFFF, 16'd0, 16'd0, 16'd0);
    push(4'b0001, 16'hFFFF);
`ifdef ACCUM_SAT_EN
    push(4'b0001, 16'hFFFF);
`else
    push(4'b0001, 16'hFFFE);
`endif
    job("ovf", 2, 4'b0001, -1, -1);
    chk("ovf.flag", 32'(ovf), 32'd1);

    // Stray start mid-job and a 3-cycle request gap; pointer now at 1.
    set_lanes(16'd1, 16'd2, 16'd3, 16'd4);
    push(4'b0010, 16'd2);
    push(4'b0100, 16'd5);
    push(4'b1000, 16'd9);
    push(4'b0001, 16'd10);
    push(4'b0010, 16'd12);
    job("gap", 5, 4'b1111, 2, 1);
    chk("gap.ovf", 32'(ovf), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
